aes_bram_responder: RTL
=======================

Name: aes_bram_responder

Overview:
- Target-side BRAM port controller that services word read/write requests from the AES control FSM.
- Converts level start/complete handshake requests (byte addresses) into single-port BRAM accesses with configurable read latency.
- Sits between the AES control FSM and one BRAM port; reports range and alignment errors and counts serviced accesses for debug readback.

Parameters:
- ADDR_W, 10, BRAM word-address width; window is 2^ADDR_W 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- RD_LAT, 1, BRAM read latency in cycles from the enable edge to valid data; legal 1..4.

Ports:
- aes_clk  in  1  clock; all logic on posedge.
- aes_rst_n  in  1  asynchronous active-low reset.
- aes_start_read  in  1  read request level; held until bram_complete is seen.
- aes_start_write  in  1  write request level; held until bram_complete is seen.
- aes_bram_addr  in  32  read byte address.
- aes_bram_write_addr  in  32  write byte address.
- aes_bram_write_data  in  32  write data.
- aes_bram_read_data  out  32  read data; valid while bram_complete is high after a read.
- bram_complete  out  1  request done; held until the start level drops.
- bram_err  out  1  last request faulted; valid while bram_complete is high.
- bram_en  out  1  BRAM port enable.
- bram_we  out  4  BRAM byte write enables.
- bram_addr  out  ADDR_W  BRAM word address.
- bram_wrdata  out  32  BRAM write data.
- bram_rddata  in  32  BRAM read data.
- access_cnt  out  16  count of successful accesses; wraps 16'hFFFF -> 0.

Behaviour:
- Reset (asynchronous): all outputs 0, state IDLE, latency counter 0.
- All outputs are registered.
- States:
  - IDLE: accept a request.
  - WR: one-cycle BRAM write.
  - RD_EN: one-cycle BRAM read enable.
  - RD_WAIT: count RD_LAT.
  - DONE: hold complete.
- Accept (edge E0, state IDLE):
  - A request starts when aes_start_read or aes_start_write is sampled high.
  - If both are high, write wins. The read stays pending and is served after that write finishes and returns to IDLE.
  - Offset = addr - BASE_ADDR, 32-bit unsigned.
  - Fault if addr[1:0] != 0, or addr < BASE_ADDR, or offset[31:2] >= 2^ADDR_W.
- Fault: no BRAM activity. bram_complete=1 and bram_err=1 from E1, then DONE. For a read, aes_bram_read_data=0.
- Write:
  - From E0 to E1: bram_en=1, bram_we=4'hF, bram_addr=offset[ADDR_W+1:2], bram_wrdata=data.
  - At E1: bram_en and bram_we return to 0; bram_complete rises; access_cnt increments; go to DONE.
- Read:
  - From E0 to E1: bram_en=1, bram_we=0, address driven.
  - Edges E1..E(RD_LAT): wait in RD_WAIT.
  - At E(1+RD_LAT): capture bram_rddata into aes_bram_read_data, bram_complete rises, access_cnt increments.
  - Read latency from accept to complete is RD_LAT+1 cycles.
- DONE:
  - bram_complete, bram_err and aes_bram_read_data are held.
  - When the serviced start signal is sampled low, bram_complete and bram_err clear at that edge and the state returns to IDLE.
  - The earliest next accept is the following edge, so back-to-back requests need at least one low cycle of start.
- Address, data and start may change freely while in DONE. They are only sampled in IDLE.
- bram_err clears on the next accepted request.
- Reset mid-operation: the access is abandoned, outputs return to reset values, and no BRAM write is issued after reset asserts.

Test Plan:
- Write 0xCAFEBABE to byte addr 0x10 (BASE_ADDR=0) -> bram_we=4'hF, bram_addr=4, bram_wrdata=0xCAFEBABE for one cycle; bram_complete rises 1 cycle after accept; access_cnt=1.
- Read addr 0x10 with RD_LAT=1 model -> aes_bram_read_data=0xCAFEBABE, complete 2 cycles after accept; complete held until start drops, then low next cycle.
- Four-word read sequence at 0x0,0x4,0x8,0xC (start drops for 1 cycle between words) -> four completes, data matches preloaded words, access_cnt=4.
- Fault cases:
  - Addr 0x6 -> bram_err=1, no bram_en.
  - Addr 0x1000 with ADDR_W=10 -> bram_err=1, no bram_en.
  - access_cnt unchanged in both cases.
- Read and write raised in the same cycle -> write serviced first; read is accepted only after the write's start drops and IDLE re-samples.
- Assert aes_rst_n=0 during RD_WAIT -> all outputs 0 immediately. After reset release with start low, the block is in IDLE and the next read completes normally.

Source files
------------

// File: rtl/aes_bram_responder.sv
// BRAM port responder for the AES control FSM: turns level start/complete
// word requests (byte addresses) into single-port BRAM accesses.
module aes_bram_responder #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          RD_LAT    = 1
) (
  input  logic              aes_clk,
  input  logic              aes_rst_n,
  input  logic              aes_start_read,
  input  logic              aes_start_write,
  input  logic [31:0]       aes_bram_addr,
  input  logic [31:0]       aes_bram_write_addr,
  input  logic [31:0]       aes_bram_write_data,
  output logic [31:0]       aes_bram_read_data,
  output logic              bram_complete,
  output logic              bram_err,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_wrdata,
  input  logic [31:0]       bram_rddata,
  output logic [15:0]       access_cnt
);

  typedef enum logic [2:0] {IDLE, WR, RD_EN, RD_WAIT, ERR, DONE} state_t;

  state_t      state;
  logic        is_wr;
  logic [2:0]  lat_cnt;
  logic [31:0] req_addr;

  function automatic logic addr_fault(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a[1:0] != 2'b00) || (a < BASE_ADDR) || ((off >> (ADDR_W + 2)) != 32'd0);
  endfunction

  function automatic logic [ADDR_W-1:0] word_addr(input logic [31:0] a);
    return ADDR_W'((a - BASE_ADDR) >> 2);
  endfunction

  // Write has priority; a concurrent read stays pending until IDLE re-samples.
  assign req_addr = aes_start_write ? aes_bram_write_addr : aes_bram_addr;

  always_ff @(posedge aes_clk or negedge aes_rst_n) begin
    if (!aes_rst_n) begin
      state              <= IDLE;
      is_wr              <= 1'b0;
      lat_cnt            <= 3'd0;
      aes_bram_read_data <= 32'd0;
      bram_complete      <= 1'b0;
      bram_err           <= 1'b0;
      bram_en            <= 1'b0;
      bram_we            <= 4'h0;
      bram_addr          <= '0;
      bram_wrdata        <= 32'd0;
      access_cnt         <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (aes_start_write || aes_start_read) begin
            is_wr    <= aes_start_write;
            bram_err <= 1'b0;
            if (addr_fault(req_addr)) begin
              state <= ERR;
            end else if (aes_start_write) begin
              bram_en     <= 1'b1;
              bram_we     <= 4'hF;
              bram_addr   <= word_addr(req_addr);
              bram_wrdata <= aes_bram_write_data;
              state       <= WR;
            end else begin
              bram_en   <= 1'b1;
              bram_we   <= 4'h0;
              bram_addr <= word_addr(req_addr);
              state     <= RD_EN;
            end
          end
        end
        WR: begin
          bram_en       <= 1'b0;
          bram_we       <= 4'h0;
          bram_complete <= 1'b1;
          access_cnt    <= access_cnt + 16'd1;
          state         <= DONE;
        end
        RD_EN: begin
          bram_en <= 1'b0;
          lat_cnt <= 3'd1;
          state   <= RD_WAIT;
        end
        RD_WAIT: begin
          if (lat_cnt == 3'(RD_LAT)) begin
            aes_bram_read_data <= bram_rddata;
            bram_complete      <= 1'b1;
            access_cnt         <= access_cnt + 16'd1;
            state              <= DONE;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        ERR: begin
          bram_complete <= 1'b1;
          bram_err      <= 1'b1;
          if (!is_wr) aes_bram_read_data <= 32'd0;
          state <= DONE;
        end
        DONE: begin
          // Release only when the start level that was serviced drops.
          if (is_wr ? !aes_start_write : !aes_start_read) begin
            bram_complete <= 1'b0;
            bram_err      <= 1'b0;
            lat_cnt       <= 3'd0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
